// File: rtl/mod_ctrl_pkg.sv
// mod_ctrl_pkg: shared types and helpers for the mod-N counter sequencing
// controller (state encoding, minimum modulus, modulus clamp).
package mod_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int unsigned MIN_MOD = 2;

   // Clamp a requested modulus into MIN_MOD..2^w. The caller narrows the
   // 32-bit result back to its own w+1-bit modulus register.
   function automatic logic [31:0] clamp_mod(input logic [31:0] m,
                                             input int unsigned w);
      logic [31:0] max_mod;
      max_mod = 32'd1 << w;
      if (m < 32'(MIN_MOD)) begin
         return 32'(MIN_MOD);
      end else if (m > max_mod) begin
         return max_mod;
      end else begin
         return m;
      end
   endfunction

endpackage

// File: rtl/mod_n_counter.sv
// mod_n_counter: counter datapath for the sequencing controller. Counts
// 0..modulus-1 while enabled, wraps on terminal count, clears on request.
// The modulus is WIDTH+1 bits wide so that a full 2^WIDTH period is legal.
module mod_n_counter #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [WIDTH:0]   modulus_i,
   output logic [WIDTH-1:0] q_o,
   output logic             tc_o
);

   localparam logic [WIDTH:0]   ONE_M = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONE_Q = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic             at_term;

   // Terminal value is compared at full modulus width so 2^WIDTH never aliases.
   assign at_term = ({1'b0, cnt_q} == (modulus_i - ONE_M));
   assign tc_o    = enable_i & at_term;
   assign q_o     = cnt_q;

   // Next count: clear dominates, otherwise increment with wrap at terminal.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = at_term ? '0 : (cnt_q + ONE_Q);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mod_counter_ctrl.sv
// mod_counter_ctrl: sequencing controller for a mod-N counter. Holds a
// runtime modulus and repeat count loaded over a valid/ready handshake,
// runs a fixed number of full periods (or free-runs when reps is 0),
// flags every terminal count and reports completion.
// Optional feature macro: MOD_CTRL_PAUSE_EN enables the pause input and
// the PAUSE state; without it pause is ignored and RUN counts every cycle.
module mod_counter_ctrl
   import mod_ctrl_pkg::*;
#(
   parameter int WIDTH       = 5,
   parameter int DEFAULT_MOD = 30,
   parameter int REPS_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [WIDTH:0]    cfg_mod,
   input  logic [REPS_W-1:0] cfg_reps,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   output logic [WIDTH-1:0]  q,
   output logic              tc,
   output logic              busy,
   output logic              done
);

   localparam int MW = WIDTH + 1;
   localparam logic [REPS_W-1:0] ONE_R = {{(REPS_W-1){1'b0}}, 1'b1};

   state_e            state_q;
   state_e            state_d;
   logic [WIDTH:0]    mod_q;
   logic [WIDTH:0]    mod_d;
   logic [REPS_W-1:0] reps_q;
   logic [REPS_W-1:0] reps_d;
   logic [REPS_W-1:0] per_q;
   logic [REPS_W-1:0] per_d;
   logic              ready_q;
   logic              ready_d;
   logic              busy_q;
   logic              busy_d;
   logic              done_q;
   logic              done_d;

   logic              cfg_fire;
   logic [WIDTH:0]    cfg_mod_cl;
   logic              last_period;
   logic              cnt_clear;
   logic              cnt_en;
   logic [WIDTH-1:0]  cnt_val;
   logic              cnt_tc;
   logic              launching;

   // ready_q is high exactly in IDLE/DONE, so it qualifies the handshake.
   assign cfg_fire    = cfg_valid & ready_q;
   assign cfg_mod_cl  = MW'(clamp_mod(32'(cfg_mod), WIDTH));
   // The period now completing is the last one only for a bounded run.
   assign last_period = (reps_q != '0) && (per_q == (reps_q - ONE_R));
   assign launching   = (state_d == ST_RUN) &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign cnt_en      = (state_q == ST_RUN);
   assign cnt_clear   = stop | launching;

`ifndef MOD_CTRL_PAUSE_EN
   logic unused_pause;
   assign unused_pause = pause;
`endif

   mod_n_counter #(
      .WIDTH(WIDTH)
   ) u_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (cnt_clear),
      .enable_i (cnt_en),
      .modulus_i(mod_q),
      .q_o      (cnt_val),
      .tc_o     (cnt_tc)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: stop dominates, then completion, then pause.
   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (cnt_tc && last_period) begin
                  state_d = ST_DONE;
`ifdef MOD_CTRL_PAUSE_EN
               end else if (pause) begin
                  state_d = ST_PAUSE;
`endif
               end
            end
            ST_PAUSE: begin
`ifdef MOD_CTRL_PAUSE_EN
               if (!pause) state_d = ST_RUN;
`else
               state_d = ST_RUN;
`endif
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs and datapath control: config capture, period count, flags.
   always_comb begin
      mod_d   = mod_q;
      reps_d  = reps_q;
      per_d   = per_q;
      if (cfg_fire) begin
         mod_d  = cfg_mod_cl;
         reps_d = cfg_reps;
      end
      if (launching) begin
         per_d = '0;
      end else if ((state_q == ST_RUN) && cnt_tc && !stop) begin
         per_d = (per_q == '1) ? per_q : (per_q + ONE_R);
      end
      ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
      busy_d  = (state_d == ST_RUN)  || (state_d == ST_PAUSE);
      done_d  = (state_d == ST_DONE);
   end

   // Configuration, period counter and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mod_q   <= MW'(DEFAULT_MOD);
         reps_q  <= ONE_R;
         per_q   <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         mod_q   <= mod_d;
         reps_q  <= reps_d;
         per_q   <= per_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign cfg_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign q         = cnt_val;
   assign tc        = cnt_tc;

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Scoreboard bench for mod_counter_ctrl: the driver applies directed and
// random stimulus, advances a behavioural model and queues the expected
// outputs; a monitor pops and compares after every clock edge and every
// asynchronous reset assertion.
module tb_mod_counter_ctrl;

   localparam int WIDTH       = 5;
   localparam int DEFAULT_MOD = 30;
   localparam int REPS_W      = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [WIDTH:0]    cfg_mod;
   logic [REPS_W-1:0] cfg_reps;
   logic              start;
   logic              stop;
   logic              pause;
   logic [WIDTH-1:0]  q;
   logic              tc;
   logic              busy;
   logic              done;

   typedef struct {
      int q;
      bit tc;
      bit busy;
      bit done;
      bit rdy;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   mon_go = 1'b0;

   // behavioural model
   int m_mod, m_reps, m_cnt, m_per;
   bit m_run, m_pau, m_fin;

   always #5 clk = ~clk;

   mod_counter_ctrl #(
      .WIDTH(WIDTH), .DEFAULT_MOD(DEFAULT_MOD), .REPS_W(REPS_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_mod(cfg_mod), .cfg_reps(cfg_reps), .start(start), .stop(stop),
      .pause(pause), .q(q), .tc(tc), .busy(busy), .done(done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
      end
   endtask

   task automatic model_reset();
      m_mod = DEFAULT_MOD; m_reps = 1; m_cnt = 0; m_per = 0;
      m_run = 0; m_pau = 0; m_fin = 0;
   endtask

   task automatic model_step(input bit st, input bit sp, input bit pa, input bit cv,
                             input int cm, input int cr);
      bit rdy;
      bit pa_eff;
`ifdef MOD_CTRL_PAUSE_EN
      pa_eff = pa;
`else
      pa_eff = 1'b0;
`endif
      rdy = !m_run;
      if (cv && rdy) begin
         m_mod  = (cm < 2) ? 2 : ((cm > (1 << WIDTH)) ? (1 << WIDTH) : cm);
         m_reps = cr;
      end
      if (sp) begin
         m_run = 0; m_pau = 0; m_fin = 0; m_cnt = 0;
      end else if (!m_run) begin
         if (st) begin
            m_run = 1; m_fin = 0; m_cnt = 0; m_per = 0;
         end
      end else if (m_pau) begin
         if (!pa_eff) m_pau = 0;
      end else if (m_cnt == m_mod - 1) begin
         m_cnt = 0;
         if (m_per < 255) m_per++;
         if (m_reps != 0 && m_per == m_reps) begin
            m_run = 0; m_fin = 1;
         end else if (pa_eff) begin
            m_pau = 1;
         end
      end else begin
         m_cnt++;
         if (pa_eff) m_pau = 1;
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.q    = m_cnt;
      e.tc   = m_run && !m_pau && (m_cnt == m_mod - 1);
      e.busy = m_run;
      e.done = m_fin;
      e.rdy  = !m_run;
      exp_q.push_back(e);
   endtask

   // one clock cycle of stimulus, entered and left at a falling edge
   task automatic cyc(input bit st, input bit sp, input bit pa, input bit cv,
                      input int cm, input int cr);
      start = st; stop = sp; pause = pa; cfg_valid = cv;
      cfg_mod = (WIDTH+1)'(cm); cfg_reps = REPS_W'(cr);
      model_step(st, sp, pa, cv, cm, cr);
      push_exp();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic pulse_reset();
      start = 0; stop = 0; pause = 0; cfg_valid = 0;
      model_reset();
      push_exp();          // checked right after the asynchronous assertion
      rst_n = 1'b0;
      push_exp();          // checked at the edge while reset is held
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_until_cnt(input int target);
      for (int i = 0; i < 200 && m_cnt != target; i++) idle(1);
      chk("reach_count", 32'(m_cnt), 32'(target));
   endtask

   // monitor: compare every observation against the oldest queued expectation
   initial begin
      exp_t e;
      wait (mon_go);
      forever begin
         @(posedge clk or negedge rst_n);
         #1;
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_sample at %0t: queue empty, expected an entry", $time);
         end else begin
            e = exp_q.pop_front();
            chk("q",         32'(q),         32'(e.q));
            chk("tc",        32'(tc),        32'(e.tc));
            chk("busy",      32'(busy),      32'(e.busy));
            chk("done",      32'(done),      32'(e.done));
            chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
         end
      end
   end

   // driver
   initial begin
      bit st, sp, pa, cv;
      int cm, cr;
      start = 0; stop = 0; pause = 0; cfg_valid = 0; cfg_mod = '0; cfg_reps = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      mon_go = 1'b1;
      push_exp();
      @(negedge clk);
      rst_n = 1'b1;

      // default configuration, single period
      cyc(1, 0, 0, 0, 0, 0);
      idle(34);
      // new config in the start cycle: mod 10, 3 periods
      cyc(1, 0, 0, 1, 10, 3);
      idle(34);
      // free-run, stop at q=17
      cyc(1, 0, 0, 1, 30, 0);
      run_until_cnt(17);
      cyc(0, 1, 0, 0, 0, 0);
      idle(3);
      // config offered while running is ignored, then accepted after done
      cyc(1, 0, 0, 1, 30, 1);
      for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 5, 2);
      idle(22);
      cyc(0, 0, 0, 1, 5, 2);
      cyc(1, 0, 0, 0, 0, 0);
      idle(12);
      // pause held for 4 cycles around q=12
      cyc(1, 0, 0, 1, 30, 1);
      run_until_cnt(11);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0);
      idle(24);
      // asynchronous reset mid-run, configuration reverts
      cyc(1, 0, 0, 1, 7, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 32, 0);
      run_until_cnt(20);
      pulse_reset();
      cyc(1, 0, 0, 0, 0, 0);
      idle(32);
      // modulus 1 and 0 clamp to 2; oversized clamps to 32
      cyc(1, 0, 0, 1, 1, 3);
      idle(8);
      cyc(1, 0, 0, 1, 0, 2);
      idle(6);
      cyc(1, 0, 0, 1, 63, 1);
      idle(34);

      // randomized traffic
      for (int n = 0; n < 5000; n++) begin
         st = ($urandom_range(0, 7) == 0);
         sp = ($urandom_range(0, 99) == 0);
         pa = ($urandom_range(0, 9) == 0);
         cv = ($urandom_range(0, 3) == 0);
         cm = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12))
                                          : int'($urandom_range(0, 63));
         cr = int'($urandom_range(0, 4));
         if ($urandom_range(0, 499) == 0) pulse_reset();
         else cyc(st, sp, pa, cv, cm, cr);
      end

      idle(2);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod_counter_ctrl.md
# mod_counter_ctrl

Sequencing controller for the team's mod-N counters. It holds a programmable modulus and repeat count, loaded through a valid/ready configuration handshake. It starts, stops and optionally pauses the count, and runs a fixed number of full periods or free-runs. It flags each terminal count and signals completion. It sits between a host/control FSM and the counter datapath, replacing hard-wired NAND-decode resets with a runtime-configurable terminal value.

## Interface
- WIDTH, 5: counter width; modulus range 2..2^WIDTH.
- DEFAULT_MOD, 30: modulus after reset.
- REPS_W, 8: repeat-count width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted.
- cfg_mod  in  WIDTH+1  modulus; 0 or 1 is clamped to 2; values above 2^WIDTH are clamped to 2^WIDTH.
- cfg_reps  in  REPS_W  periods to run; 0 = free-run.
- start  in  1  begin counting (level-sampled).
- stop  in  1  abort to IDLE.
- pause  in  1  hold count (MOD_CTRL_PAUSE_EN only).
- q  out  WIDTH  current count.
- tc  out  1  terminal-count strobe.
- busy  out  1  state is RUN or PAUSE.
- done  out  1  state is DONE.

## Operation
- The state machine has four states: IDLE, RUN, PAUSE, DONE.
- Reset values: state IDLE, q=0, mod_r=DEFAULT_MOD, reps_r=1, period count=0, cfg_ready=1, tc=0, busy=0, done=0.
- Config handshake:
  - cfg_ready=1 only in IDLE or DONE.
  - The transfer happens on a cycle where cfg_valid && cfg_ready; mod_r and reps_r are written.
  - In RUN or PAUSE, cfg_valid is ignored and nothing is written.
- IDLE or DONE with start=1 and stop=0: go to RUN, q=0, period count=0. A config transfer in the same cycle is applied first, so the new values govern the run.
- RUN:
  - q increments by 1 each cycle.
  - tc=1 combinationally when q==mod_r-1. On that edge q wraps to 0 and the period count increments.
  - If reps_r≠0 and the completing period is number reps_r, go to DONE with q=0.
  - reps_r=0: never reaches DONE; the period count saturates.
- stop=1 in RUN, PAUSE or DONE: go to IDLE, q=0. stop has priority over start, pause and tc.
- PAUSE:
  - Entered from RUN when pause=1. q holds and tc=0.
  - Returns to RUN on the first cycle pause=0.
- DONE: holds q=0 until start (rerun) or stop (IDLE).
- Arithmetic:
  - The comparison uses a WIDTH+1-bit mod_r, so modulus 2^WIDTH works.
  - q never exceeds mod_r-1.
- Reset mid-run: returns immediately to the reset values, asynchronously; the configuration reverts to DEFAULT_MOD and reps 1.

## Timing
- Start latency: start sampled at edge k gives RUN with q=0 after edge k; q=1 after k+1.
- One period takes exactly mod_r RUN cycles. tc is high for one cycle per period, on the q=mod_r-1 cycle.
- Done latency: done rises on the edge after the final tc. Total RUN time is reps_r×mod_r cycles, excluding PAUSE cycles.
- stop takes effect at the next edge: q=0 and busy=0 one cycle after sampling.
- All outputs except tc are registered. tc is decoded from registered q and state.

## Configuration
- MOD_CTRL_PAUSE_EN defined: pause input and PAUSE state are present, as described above.
- MOD_CTRL_PAUSE_EN undefined: the pause port is still present but ignored. PAUSE is unreachable and RUN counts every cycle.

## Structure
- Package mod_ctrl_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - the MIN_MOD=2 constant;
  - the clamp function for cfg_mod.
- Sub-module mod_n_counter contains the counter datapath:
  - inputs: clear, enable, modulus;
  - outputs: q, tc.
  - The controller owns the FSM, configuration registers and period counter.

## Test plan
- Default config: start once → tc at the 30th RUN cycle (q=29), done on the next cycle, q=0.
- cfg_mod=10, cfg_reps=3, start in the same cycle → 3 tc pulses, 10 cycles apart; done after 30 RUN cycles.
- cfg_reps=0, start, stop when q=17 → IDLE next cycle with q=0 and busy=0; no done.
- cfg_valid in RUN with cfg_mod=5 → cfg_ready=0, and the run continues at mod 30. After done, the transfer completes.
- With MOD_CTRL_PAUSE_EN: pause for 4 cycles at q=12 → q holds at 12 with tc=0; done is delayed by exactly 4 cycles.
- rst_n pulsed low at q=20 → q=0 and IDLE immediately; mod_r reverts to 30. Separately, cfg_mod=1 → runs as mod 2.
